// File: rtl/mem_pkg.sv
// Shared size/state encodings and default data-RAM depth for the MEM-stage load/store path.
package mem_pkg;

    localparam int unsigned ADDR_WORDS_DEF = 3072;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Reserved size 3 falls into the word strobe.
    function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_strobe = 4'b0001 << off;
            SZ_HALF: lane_strobe = off[1] ? 4'b1100 : 4'b0011;
            default: lane_strobe = 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension of a 32-bit RAM word; returns 0 when en_i is low.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  off_i,
    input  logic        en_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (off_i)
            2'd0:    byte_v = rdata_i[7:0];
            2'd1:    byte_v = rdata_i[15:8];
            2'd2:    byte_v = rdata_i[23:16];
            default: byte_v = rdata_i[31:24];
        endcase
        half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        data_o = '0;
        if (en_i) begin
            case (size_i)
                SZ_BYTE: data_o = {{24{byte_v[7] & ~unsigned_i}}, byte_v};
                SZ_HALF: data_o = {{16{half_v[15] & ~unsigned_i}}, half_v};
                default: data_o = rdata_i;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store front end for dm_ram: strobes, lane-replicated store data, aligned load result.
// Optional MISALIGN_TRAP_EN: flag misaligned half/word accesses and suppress their effects.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WORDS = ADDR_WORDS_DEF,
    parameter int unsigned IDX_W      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              ex_valid_i,
    input  logic              ex_load_i,
    input  logic              ex_store_i,
    input  logic [1:0]        ex_size_i,
    input  logic              ex_unsigned_i,
    input  logic [31:0]       ex_addr_i,
    input  logic [31:0]       ex_wdata_i,
    input  logic [4:0]        ex_rd_i,
    output logic              ready_o,
    output logic [IDX_W-1:0]  dm_addr_o,
    output logic              dm_en_o,
    output logic [3:0]        dm_we_o,
    output logic [31:0]       dm_din_o,
    input  logic [31:0]       dm_dout_i,
    output logic              wb_valid_o,
    output logic              wb_load_o,
    output logic [4:0]        wb_rd_o,
    output logic [31:0]       wb_data_o,
    output logic              misalign_o
);

    state_e      state_q;
    logic        accept;
    logic        in_range;
    logic        mis;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        uns_q;
    logic        ok_q;
    logic        wb_valid_q;
    logic        wb_load_q;
    logic        mis_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] hold_q;
    logic [31:0] align_data;

    assign ready_o   = ~stall_i;
    // Reset drops any presented request, so no RAM write can slip through.
    assign accept    = ex_valid_i & ~stall_i & rst_n;
    assign in_range  = ({2'b00, ex_addr_i[31:2]} < ADDR_WORDS);
    assign dm_addr_o = ex_addr_i[IDX_W+1:2];

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        case (ex_size_i)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = ex_addr_i[0];
            default: mis = |ex_addr_i[1:0];
        endcase
    end
`else
    assign mis = 1'b0;
`endif

    assign dm_we_o = (accept & ex_store_i & in_range & ~mis)
                   ? lane_strobe(ex_size_i, ex_addr_i[1:0]) : 4'h0;
    assign dm_en_o = |dm_we_o;

    always_comb begin
        case (ex_size_i)
            SZ_BYTE: dm_din_o = {4{ex_wdata_i[7:0]}};
            SZ_HALF: dm_din_o = {2{ex_wdata_i[15:0]}};
            default: dm_din_o = ex_wdata_i;
        endcase
    end

    load_align u_align (
        .rdata_i    (dm_dout_i),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .off_i      (off_q),
        .en_i       (ok_q),
        .data_o     (align_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b0;
            wb_load_q  <= 1'b0;
            wb_rd_q    <= '0;
            mis_q      <= 1'b0;
            size_q     <= '0;
            off_q      <= '0;
            uns_q      <= 1'b0;
            ok_q       <= 1'b0;
            hold_q     <= '0;
        end else if (state_q != IDLE && stall_i) begin
            // dm_ram keeps re-reading, so the RESP result must be frozen on entry to HOLD.
            if (state_q == RESP) begin
                state_q <= HOLD;
                hold_q  <= align_data;
            end
        end else if (accept) begin
            state_q    <= RESP;
            wb_valid_q <= 1'b1;
            wb_load_q  <= ex_load_i & ~mis;
            wb_rd_q    <= ex_rd_i;
            mis_q      <= mis;
            size_q     <= ex_size_i;
            off_q      <= ex_addr_i[1:0];
            uns_q      <= ex_unsigned_i;
            ok_q       <= ex_load_i & in_range & ~mis;
        end else begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b0;
            wb_load_q  <= 1'b0;
            mis_q      <= 1'b0;
        end
    end

    always_comb begin
        case (state_q)
            RESP:    wb_data_o = align_data;
            HOLD:    wb_data_o = hold_q;
            default: wb_data_o = '0;
        endcase
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_load_o  = wb_load_q;
    assign wb_rd_o    = wb_rd_q;
    assign misalign_o = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural 1-cycle registered dm_ram model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n, stall_i, ex_valid_i, ex_load_i, ex_store_i, ex_unsigned_i;
    logic [1:0]  ex_size_i;
    logic [31:0] ex_addr_i, ex_wdata_i;
    logic [4:0]  ex_rd_i;
    logic        ready_o, dm_en_o, wb_valid_o, wb_load_o, misalign_o;
    logic [11:0] dm_addr_o;
    logic [3:0]  dm_we_o;
    logic [31:0] dm_din_o, wb_data_o;
    logic [4:0]  wb_rd_o;
    bit   [31:0] dm_dout;
    bit   [31:0] mem [0:4095];

    typedef struct { logic [3:0] we; logic [31:0] din; } iss_t;
    typedef struct { logic load; logic [4:0] rd; logic [31:0] data; logic mis; } wb_t;
    iss_t iq[$];
    wb_t  wq[$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] w10;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WORDS(3072), .IDX_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .ex_valid_i(ex_valid_i),
        .ex_load_i(ex_load_i), .ex_store_i(ex_store_i), .ex_size_i(ex_size_i),
        .ex_unsigned_i(ex_unsigned_i), .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i),
        .ex_rd_i(ex_rd_i), .ready_o(ready_o), .dm_addr_o(dm_addr_o), .dm_en_o(dm_en_o),
        .dm_we_o(dm_we_o), .dm_din_o(dm_din_o), .dm_dout_i(dm_dout), .wb_valid_o(wb_valid_o),
        .wb_load_o(wb_load_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .misalign_o(misalign_o)
    );

    function automatic bit [31:0] merge(input bit [31:0] old, input logic [31:0] d, input logic [3:0] we);
        bit [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (we[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // RAM model; words beyond the depth read back as all-ones so a leaked read would show.
    always @(posedge clk) begin
        if (dm_en_o && dm_addr_o < 12'd3072)
            mem[dm_addr_o] <= merge(mem[dm_addr_o], dm_din_o, dm_we_o);
        dm_dout <= (dm_addr_o >= 12'd3072) ? 32'hFFFF_FFFF : mem[dm_addr_o];
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        iss_t ie;
        wb_t  we;
        if (ex_valid_i && ready_o) begin
            if (iq.size() == 0) begin
                checks++; errors++;
                $display("FAIL issue_unexpected actual=accepted required=none");
            end else begin
                ie = iq.pop_front();
                chk("dm_we", 32'(dm_we_o), 32'(ie.we));
                chk("dm_en", 32'(dm_en_o), 32'(|ie.we));
                chk("dm_din", dm_din_o, ie.din);
            end
        end
        if (stall_i) begin
            chk("ready_stall", 32'(ready_o), 32'd0);
            chk("no_write_stall", 32'(dm_en_o), 32'd0);
        end
        if (wb_valid_o) begin
            if (wq.size() == 0) begin
                checks++; errors++;
                $display("FAIL wb_unexpected actual=valid required=none");
            end else begin
                we = wq.pop_front();
                chk("wb_load", 32'(wb_load_o), 32'(we.load));
                chk("wb_rd", 32'(wb_rd_o), 32'(we.rd));
                chk("wb_data", wb_data_o, we.data);
                chk("misalign", 32'(misalign_o), 32'(we.mis));
            end
        end
    end

    task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        ex_valid_i = 1'b1; ex_load_i = ld; ex_store_i = st; ex_size_i = sz;
        ex_unsigned_i = uns; ex_addr_i = a; ex_wdata_i = wd; ex_rd_i = rd;
    endtask

    task automatic req(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [3:0] exp_we, input logic [31:0] exp_din,
                       input logic [31:0] exp_data, input logic exp_mis);
        drive(ld, st, sz, uns, a, wd, rd);
        iq.push_back('{exp_we, exp_din});
        wq.push_back('{ld & ~exp_mis, rd, exp_data, exp_mis});
        @(posedge clk); #1;
        ex_valid_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0);
        ex_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_wb_load", 32'(wb_load_o), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd_o), 32'd0);
        chk("rst_wb_data", wb_data_o, 32'd0);
        chk("rst_misalign", 32'(misalign_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        req(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678, 5'd0, 4'hF, 32'h1234_5678, 32'h0, 1'b0);
        req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd5, 4'h0, 32'h0, 32'h1234_5678, 1'b0);
        req(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF, 5'd0, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);

        // Load then 3 stalled cycles; RAM address moves to 0x20 and a blocked store is presented.
        req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd6, 4'h0, 32'h0, 32'h1234_5678, 1'b0);
        stall_i = 1'b1;
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h5555_5555, 5'd0);
        for (int i = 0; i < 3; i++) wq.push_back('{1'b1, 5'd6, 32'h1234_5678, 1'b0});
        repeat (3) @(posedge clk);
        #1;
        stall_i = 1'b0; ex_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        req(1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h7777_77AB, 5'd0, 4'b1000, 32'hABAB_ABAB, 32'h0, 1'b0);
        req(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 5'd1, 4'h0, 32'h0, 32'hFFFF_FFAB, 1'b0);
        req(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 5'd2, 4'h0, 32'h0, 32'h0000_00AB, 1'b0);
        req(1'b0, 1'b1, 2'd1, 1'b0, 32'h12, 32'h9999_8001, 5'd0, 4'b1100, 32'h8001_8001, 32'h0, 1'b0);
        req(1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 5'd3, 4'h0, 32'h0, 32'hFFFF_8001, 1'b0);
        req(1'b1, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 5'd4, 4'h0, 32'h0, 32'h0000_8001, 1'b0);
        req(1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 5'd8, 4'h0, 32'h0, 32'h0000_0078, 1'b0);
        req(1'b1, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 5'd9, 4'h0, 32'h0, 32'h0000_0056, 1'b0);
        req(1'b1, 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 5'd10, 4'h0, 32'h0, 32'h0000_5678, 1'b0);
        req(1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 5'd11, 4'h0, 32'h0, 32'h8001_5678, 1'b0);

        req(1'b0, 1'b1, 2'd2, 1'b0, 32'h3000, 32'h0BAD_0BAD, 5'd0, 4'h0, 32'h0BAD_0BAD, 32'h0, 1'b0);
        req(1'b1, 1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, 5'd12, 4'h0, 32'h0, 32'h0, 1'b0);

`ifdef MISALIGN_TRAP_EN
        req(1'b0, 1'b1, 2'd2, 1'b0, 32'h11, 32'hCAFE_F00D, 5'd0, 4'h0, 32'hCAFE_F00D, 32'h0, 1'b1);
        w10 = 32'h8001_5678;
`else
        req(1'b0, 1'b1, 2'd2, 1'b0, 32'h11, 32'hCAFE_F00D, 5'd0, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0);
        w10 = 32'hCAFE_F00D;
`endif
        req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd13, 4'h0, 32'h0, w10, 1'b0);

        // Reset while the load is in RESP; the store presented during reset must not write.
        req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd14, 4'h0, 32'h0, w10, 1'b0);
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h1111_1111, 5'd0);
        iq.push_back('{4'h0, 32'h1111_1111});
        @(posedge clk); #1;
        chk("rst_resp_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_resp_wb_data", wb_data_o, 32'd0);
        iq.push_back('{4'h0, 32'h1111_1111});
        @(posedge clk); #1;
        rst_n = 1'b1; ex_valid_i = 1'b0;
        @(posedge clk); #1;
        req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd15, 4'h0, 32'h0, w10, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("iq_drained", 32'(iq.size()), 32'd0);
        chk("wq_drained", 32'(wq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
